// File: rtl/vedic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vedic_pkg
// Description : Shared types and sizing helpers for the sequential
//               Urdhva-Tiryagbhyam multiplier.
//               - state_t  : controller states {IDLE, CALC, DONE}
//               - carry_w  : width of the running column carry
//               - col_w    : width of the column index counter
// Config      : VEDIC_SIGNED_EN (used by vedic_seq_mult, not here)
// Revision    : 1.0 - initial release
// ============================================================================
package vedic_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Column sum is at most WIDTH partial-product bits plus a carry below
   // 2*WIDTH, so $clog2(2*width)+1 bits can never overflow.
   function automatic int carry_w(input int width);
      return $clog2(2 * width) + 1;
   endfunction

   // Highest column index is 2*width-2 and the counter stops one past it.
   function automatic int col_w(input int width);
      return $clog2(2 * width);
   endfunction

endpackage : vedic_pkg
`default_nettype wire

// File: rtl/vedic_column_sum.sv
`default_nettype none
// ============================================================================
// Module      : vedic_column_sum
// Description : Combinational sum of one product column: the number of
//               set partial-product bits a[i]&b[j] with i+j == k, plus the
//               incoming carry.
// Ports       : a, b      in  WIDTH  latched operands
//               k         in  COLW   column index
//               carry_in  in  CW     running carry from column k-1
//               s         out CW     column sum (product bit is s[0])
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
module vedic_column_sum
   import vedic_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic [WIDTH-1:0]           a,
   input  logic [WIDTH-1:0]           b,
   input  logic [col_w(WIDTH)-1:0]    k,
   input  logic [carry_w(WIDTH)-1:0]  carry_in,
   output logic [carry_w(WIDTH)-1:0]  s
);

   localparam int CW   = carry_w(WIDTH);
   localparam int COLW = col_w(WIDTH);
   localparam int NT   = WIDTH * WIDTH;

   logic [NT-1:0] term;
   logic [CW-1:0] acc [0:NT];

   assign acc[0] = carry_in;

   // Every partial product is masked by its diagonal, then all of them are
   // folded into a ripple accumulator; only the k-th diagonal contributes.
   for (genvar i = 0; i < WIDTH; i++) begin : g_row
      for (genvar j = 0; j < WIDTH; j++) begin : g_bit
         localparam int N = i * WIDTH + j;
         assign term[N]    = a[i] & b[j] & (k == COLW'(i + j));
         assign acc[N + 1] = acc[N] + CW'(term[N]);
      end
   end

   assign s = acc[NT];

endmodule : vedic_column_sum
`default_nettype wire

// File: rtl/vedic_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : vedic_seq_mult
// Description : Sequential vertical-and-crosswise multiplier. Resolves one
//               product column per clock with a running carry; valid/ready
//               handshake on both sides, one product in flight at a time.
// Ports       : clk        in   1        clock, rising edge
//               rst        in   1        asynchronous reset, active-high
//               in_valid   in   1        operands valid
//               in_ready   out  1        operands accepted (IDLE only)
//               a, b       in   WIDTH    multiplicand / multiplier
//               out_valid  out  1        product valid, held until taken
//               out_ready  in   1        consumer accepts product
//               product    out  2*WIDTH  a*b
// Config      : VEDIC_SIGNED_EN - two's complement operands and product
// Revision    : 1.0 - initial release
// ============================================================================
module vedic_seq_mult
   import vedic_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      a,
   input  logic [WIDTH-1:0]      b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*WIDTH-1:0]    product
);

   localparam int PW   = 2 * WIDTH;
   localparam int CW   = carry_w(WIDTH);
   localparam int COLW = col_w(WIDTH);
   localparam logic [COLW-1:0] LAST_COL = COLW'(PW - 2);

   state_t            state;
   state_t            state_nxt;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [COLW-1:0]   col;
   logic [CW-1:0]     carry;
   logic [CW-1:0]     s;
   logic              accept;
   logic              last;
   logic [PW-1:0]     col_bit;
   logic [PW-1:0]     prod_upd;
   logic [PW-1:0]     mag;
   logic [PW-1:0]     final_prod;
   logic [WIDTH-1:0]  a_lat;
   logic [WIDTH-1:0]  b_lat;

   vedic_column_sum #(
      .WIDTH    (WIDTH)
   ) u_column_sum (
      .a        (a_q),
      .b        (b_q),
      .k        (col),
      .carry_in (carry),
      .s        (s)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            if (col == LAST_COL) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            // Retiring only; a simultaneous in_valid waits for IDLE.
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   // Product bits are cleared on accept, so OR-ing in the new column bit is
   // enough. On the last column the carry's low bit (s[1]) is the MSB.
   assign col_bit  = {{(PW-1){1'b0}}, 1'b1} << col;
   assign prod_upd = product | (s[0] ? col_bit : '0);
   assign mag      = prod_upd | (s[1] ? {1'b1, {(PW-1){1'b0}}} : '0);

`ifdef VEDIC_SIGNED_EN
   logic sign_q;

   // |-2^(W-1)| wraps to 2^(W-1), which is still correct read as unsigned.
   assign a_lat      = a[WIDTH-1] ? -a : a;
   assign b_lat      = b[WIDTH-1] ? -b : b;
   assign final_prod = sign_q ? -mag : mag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         sign_q <= 1'b0;
      else if (accept) sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
   end
`else
   assign a_lat      = a;
   assign b_lat      = b;
   assign final_prod = mag;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         col     <= '0;
         carry   <= '0;
         product <= '0;
      end else if (accept) begin
         a_q     <= a_lat;
         b_q     <= b_lat;
         col     <= '0;
         carry   <= '0;
         product <= '0;
      end else if (state == CALC) begin
         col     <= col + 1'b1;
         carry   <= s >> 1;
         product <= last ? final_prod : prod_upd;
      end
   end

endmodule : vedic_seq_mult
`default_nettype wire

// File: tb/tb_vedic_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_vedic_seq_mult
// Description : Self-checking bench for vedic_seq_mult (WIDTH=8 and WIDTH=3).
//               A timeline model predicts handshake signals and products
//               from plain arithmetic; directed vectors pin literal values.
// Config      : VEDIC_SIGNED_EN - selects the signed vector set
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vedic_seq_mult;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  a, b;
   logic [2*W-1:0] product;

   logic          in_valid3, in_ready3, out_valid3, out_ready3;
   logic [2:0]    a3, b3;
   logic [5:0]    product3;

   vedic_seq_mult #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .product(product));

   vedic_seq_mult #(.WIDTH(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
      .a(a3), .b(b3), .out_valid(out_valid3), .out_ready(out_ready3),
      .product(product3));

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
`ifdef VEDIC_SIGNED_EN
      logic signed [15:0] sx;
      logic signed [15:0] sy;
      sx = $signed(x);
      sy = $signed(y);
      return 16'(sx * sy);
`else
      return 16'(x) * 16'(y);
`endif
   endfunction

   // ---------------------------------------------------- timeline model
   // Busy from the accept edge; product ready 2*W-1 edges later; retired
   // on the first edge with out_ready while ready.
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   int          m_age  = 0;
   logic [15:0] m_exp  = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_age  = 0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            m_age  = 0;
            m_exp  = ref_mul(a, b);
         end
      end else if (!m_done) begin
         m_age++;
         if (m_age == 2*W-1) m_done = 1'b1;
      end else if (out_ready) begin
         m_busy = 1'b0;
         m_done = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", in_ready, !m_busy);
         chk("out_valid", out_valid, m_done);
         if (m_done) chk("product", product, m_exp);
      end
   end

   logic [15:0] got_q[$];
   always @(posedge clk) begin
      if (!rst && out_valid && out_ready) got_q.push_back(product);
   end

   // ------------------------------------------------------ directed op
   task automatic do_op(input string name, input logic [7:0] x, input logic [7:0] y,
                        input int stall, input logic [15:0] lit);
      int n;
      a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      @(posedge clk); #1 in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk({name, "_latency"}, n, 2*W-1);
      chk({name, "_value"}, product, lit);
      repeat (stall) begin
         @(posedge clk); #1;
         chk({name, "_hold_valid"}, out_valid, 1'b1);
         chk({name, "_hold_ready"}, in_ready, 1'b0);
         chk({name, "_hold_value"}, product, lit);
      end
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      chk({name, "_retired"}, out_valid, 1'b0);
      chk({name, "_idle"}, in_ready, 1'b1);
   endtask

   logic [7:0]  pa [3] = '{8'd3, 8'd100, 8'd13};
   logic [7:0]  pb [3] = '{8'd7, 8'd2, 8'd11};
   logic [15:0] pe [3] = '{16'd21, 16'd200, 16'd143};
   int          acc_cyc [3];

   initial begin
      int n;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      in_valid3 = 1'b0; out_ready3 = 1'b0; a3 = '0; b3 = '0;

      #12;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_product", product, 16'h0);
      chk("rst_in_ready3", in_ready3, 1'b1);
      chk("rst_product3", product3, 6'h0);
      @(posedge clk); #1 rst = 1'b0;

      // WIDTH=3, 7*7: ready 2*3 edges counting the accept edge
      a3 = 3'd7; b3 = 3'd7; in_valid3 = 1'b1;
      @(posedge clk); #1 in_valid3 = 1'b0;
      n = 0;
      while (!out_valid3 && n < 50) begin @(posedge clk); #1; n++; end
      chk("w3_latency", n, 5);
`ifdef VEDIC_SIGNED_EN
      chk("w3_value", product3, 6'd1);
`else
      chk("w3_value", product3, 6'b110001);
`endif
      out_ready3 = 1'b1;
      @(posedge clk); #1 out_ready3 = 1'b0;
      chk("w3_retired", out_valid3, 1'b0);

`ifdef VEDIC_SIGNED_EN
      do_op("neg1sq", 8'hFF, 8'hFF, 0, 16'h0001);
`else
      do_op("ffsq", 8'd255, 8'd255, 0, 16'hFE01);
`endif
      do_op("zero", 8'd0, 8'd200, 0, 16'h0000);
      do_op("bp", 8'd3, 8'd5, 10, 16'd15);

      // reset while column 4 is being resolved
      a = 8'd9; b = 8'd9; in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_product", product, 16'h0);
      chk("midrst_in_ready", in_ready, 1'b1);
      #1 rst = 1'b0;
      do_op("after_rst", 8'd12, 8'd12, 0, 16'd144);

      // back-to-back with in_valid held high
      got_q.delete();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         a = pa[k]; b = pb[k];
         n = 0;
         @(negedge clk);
         while (!in_ready && n < 100) begin @(negedge clk); n++; end
         acc_cyc[k] = cyc;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("b2b_spacing01", acc_cyc[1] - acc_cyc[0], 2*W+1);
      chk("b2b_spacing12", acc_cyc[2] - acc_cyc[1], 2*W+1);
      n = 0;
      while (got_q.size() < 3 && n < 100) begin @(posedge clk); #1; n++; end
      repeat (20) @(posedge clk);
      #1;
      chk("b2b_count", got_q.size(), 3);
      for (int k = 0; k < 3; k++) begin
         if (k < got_q.size()) chk($sformatf("b2b_value%0d", k), got_q[k], pe[k]);
         else                  chk($sformatf("b2b_missing%0d", k), 0, 1);
      end
      out_ready = 1'b0;

`ifdef VEDIC_SIGNED_EN
      do_op("s_minmin", 8'h80, 8'h80, 0, 16'h4000);
      do_op("s_m3x5", 8'hFD, 8'd5, 0, 16'hFFF1);
      do_op("s_maxmin", 8'd127, 8'h80, 0, 16'hC080);
`endif

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_vedic_seq_mult
`default_nettype wire
